// File: rtl/nibble_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit slice per cycle, LSB nibble first.
// Optional subtract mode is enabled with the NSA_SUB_EN macro.
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    assign {c_out, s} = {1'b0, a} + {1'b0, b} + {4'b0, c_in};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic             a_msb;
    logic             b_msb;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_eff;
    logic             carry0;
    logic [3:0]       s;
    logic             co;

`ifdef NSA_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign carry0 = sub ? 1'b1 : c_in;
`else
    assign b_eff  = b;
    assign carry0 = c_in;
`endif

    assign in_ready = (state == IDLE) && !rst;

    // Operand registers shift right so the active nibble is always [3:0].
    four_bit_adder u_slice (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .c_in  (carry),
        .s     (s),
        .c_out (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b_eff;
                        carry <= carry0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b_eff[WIDTH-1];
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 4;
                    b_q   <= b_q >> 4;
                    sum   <= {s, sum[WIDTH-1:4]};
                    carry <= co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(NIB - 1)) begin
                        c_out     <= co;
                        ovf       <= (a_msb == b_msb) && (s[3] != a_msb);
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
